// File: rtl/sampler_pkg.sv
// sampler_pkg: shared definitions for the multi-channel capacitive sampler.
//   state_t    - scan FSM states
//   sat_sum_w  - width of an accumulator sum including the carry bit that
//                flags saturation
package sampler_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SELECT,
    S_START_CHARGE,
    S_CHARGE,
    S_PREDISCHARGE,
    S_START_DISCHARGE,
    S_DISCHARGE,
    S_OUTPUT,
    S_FIN
  } state_t;

  function automatic int unsigned sat_sum_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sampler_ch_select.sv
// sampler_ch_select: lowest-set-bit priority encoder over the remaining
// channel mask.
//   mask     in   remaining channel mask
//   idx      out  index of the lowest set bit (0 when none)
//   found    out  mask had at least one bit set
//   mask_clr out  mask with the selected bit cleared
module sampler_ch_select #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   idx,
  output logic              found,
  output logic [NUM_CH-1:0] mask_clr
);

  always_comb begin
    idx      = '0;
    found    = 1'b0;
    mask_clr = mask;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i]) begin
        found       = 1'b1;
        idx         = CH_W'(i);
        mask_clr[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_ch_sampler.sv
// multi_ch_sampler: time-multiplexes one shared drive pin across NUM_CH sense
// pins. Each enabled channel (ascending index) gets a charge phase and a
// discharge phase; both accumulate into one saturating result streamed out on
// a valid/ready interface. finish holds in FIN until start_sync drops.
//
// Ports:
//   clk_sampler, rst_sampler_sync (sync, active high), clksampleren_sync
//   start_sync, sense_in_sync[NUM_CH], ch_mask[NUM_CH], numsamples[WIDTH]
//   sense_oe/sense_out[NUM_CH], drive_oe, drive_out
//   data_valid, data_ready, data_ch[CH_W], data[WIDTH], finish
// Optional (SAMPLER_THRESHOLD_EN): thresh[WIDTH] in, touched[NUM_CH] out.
module multi_ch_sampler
  import sampler_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk_sampler,
  input  logic              rst_sampler_sync,
  input  logic              clksampleren_sync,
  input  logic              start_sync,
  input  logic [NUM_CH-1:0] sense_in_sync,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [WIDTH-1:0]  numsamples,
  output logic [NUM_CH-1:0] sense_oe,
  output logic [NUM_CH-1:0] sense_out,
  output logic              drive_oe,
  output logic              drive_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [CH_W-1:0]   data_ch,
  output logic [WIDTH-1:0]  data,
  output logic              finish
`ifdef SAMPLER_THRESHOLD_EN
  ,
  input  logic [WIDTH-1:0]  thresh,
  output logic [NUM_CH-1:0] touched
`endif
);

  localparam int unsigned SUM_W = sat_sum_w(WIDTH);

  state_t              state, state_nxt;
  logic [NUM_CH-1:0]   mask_rem, mask_nxt;
  logic [WIDTH-1:0]    ns_lat, ns_nxt;
  logic [WIDTH-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0]    acc, acc_nxt;
  logic [CH_W-1:0]     ch, ch_nxt;
  logic [NUM_CH-1:0]   soe_nxt, sout_nxt;
  logic                doe_nxt, dout_nxt;
  logic                valid_nxt;
  logic [CH_W-1:0]     dch_nxt;
  logic [WIDTH-1:0]    data_nxt;
`ifdef SAMPLER_THRESHOLD_EN
  logic [NUM_CH-1:0]   touched_nxt;
`endif

  logic                hit;
  logic [SUM_W-1:0]    sum;
  logic [WIDTH-1:0]    acc_sat;

  logic [CH_W-1:0]     sel_idx;
  logic                sel_found;
  logic [NUM_CH-1:0]   sel_clr;

  sampler_ch_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_ch_select (
    .mask     (mask_rem),
    .idx      (sel_idx),
    .found    (sel_found),
    .mask_clr (sel_clr)
  );

  // Charge counts pins still low; discharge counts pins still high.
  always_comb begin
    hit     = (state == S_CHARGE) ? ~sense_in_sync[ch] : sense_in_sync[ch];
    sum     = SUM_W'(acc) + SUM_W'(hit);
    acc_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

  assign finish = (state == S_FIN);

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_rem;
    ns_nxt    = ns_lat;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    ch_nxt    = ch;
    soe_nxt   = sense_oe;
    sout_nxt  = sense_out;
    doe_nxt   = drive_oe;
    dout_nxt  = drive_out;
    valid_nxt = data_valid;
    dch_nxt   = data_ch;
    data_nxt  = data;
`ifdef SAMPLER_THRESHOLD_EN
    touched_nxt = touched;
`endif
    case (state)
      S_IDLE: begin
        if (start_sync) begin
          mask_nxt  = ch_mask;
          ns_nxt    = (numsamples == '0) ? WIDTH'(1) : numsamples;
`ifdef SAMPLER_THRESHOLD_EN
          touched_nxt = '0;
`endif
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        soe_nxt  = '0;
        sout_nxt = '0;
        if (sel_found) begin
          ch_nxt    = sel_idx;
          mask_nxt  = sel_clr;
          acc_nxt   = '0;
          state_nxt = S_START_CHARGE;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_START_CHARGE: begin
        cnt_nxt      = ns_lat - WIDTH'(1);
        dout_nxt     = 1'b1;
        soe_nxt[ch]  = 1'b0;
        sout_nxt[ch] = 1'b0;
        state_nxt    = S_CHARGE;
      end
      S_CHARGE: begin
        acc_nxt = acc_sat;
        if (cnt == '0) state_nxt = S_PREDISCHARGE;
        else           cnt_nxt   = cnt - WIDTH'(1);
      end
      S_PREDISCHARGE: begin
        soe_nxt[ch]  = 1'b1;
        sout_nxt[ch] = 1'b1;
        doe_nxt      = 1'b1;
        dout_nxt     = 1'b1;
        state_nxt    = S_START_DISCHARGE;
      end
      S_START_DISCHARGE: begin
        dout_nxt    = 1'b0;
        soe_nxt[ch] = 1'b0;
        cnt_nxt     = ns_lat - WIDTH'(1);
        state_nxt   = S_DISCHARGE;
      end
      S_DISCHARGE: begin
        acc_nxt = acc_sat;
        if (cnt == '0) begin
          // Result registers load with the final sample already folded in.
          valid_nxt = 1'b1;
          data_nxt  = acc_sat;
          dch_nxt   = ch;
          state_nxt = S_OUTPUT;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
      S_OUTPUT: begin
        if (data_ready) begin
          valid_nxt    = 1'b0;
          sout_nxt[ch] = 1'b0;
`ifdef SAMPLER_THRESHOLD_EN
          touched_nxt[ch] = (acc >= thresh);
`endif
          state_nxt    = S_SELECT;
        end
      end
      S_FIN: begin
        if (!start_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The valid/ready handshake in OUTPUT proceeds regardless of the enable.
  always_ff @(posedge clk_sampler) begin
    if (rst_sampler_sync) begin
      state      <= S_IDLE;
      mask_rem   <= '0;
      ns_lat     <= '0;
      cnt        <= '0;
      acc        <= '0;
      ch         <= '0;
      sense_oe   <= '0;
      sense_out  <= '0;
      drive_oe   <= 1'b1;
      drive_out  <= 1'b0;
      data_valid <= 1'b0;
      data_ch    <= '0;
      data       <= '0;
`ifdef SAMPLER_THRESHOLD_EN
      touched    <= '0;
`endif
    end else if (clksampleren_sync || state == S_OUTPUT) begin
      state      <= state_nxt;
      mask_rem   <= mask_nxt;
      ns_lat     <= ns_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      ch         <= ch_nxt;
      sense_oe   <= soe_nxt;
      sense_out  <= sout_nxt;
      drive_oe   <= doe_nxt;
      drive_out  <= dout_nxt;
      data_valid <= valid_nxt;
      data_ch    <= dch_nxt;
      data       <= data_nxt;
`ifdef SAMPLER_THRESHOLD_EN
      touched    <= touched_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_multi_ch_sampler.sv
// tb_multi_ch_sampler: directed + randomized bench for multi_ch_sampler.
// The reference model derives each scan's timeline from the phase lengths
// (SELECT, START_CHARGE, n x CHARGE, PREDISCHARGE, START_DISCHARGE,
// n x DISCHARGE, OUTPUT) counted in advancing cycles, and sums hits per
// channel with plain arithmetic.
module tb_multi_ch_sampler;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int CH_W   = 2;
  localparam int SEQ_N  = 4096;
  localparam int SAT    = (1 << WIDTH) - 1;

  logic              clk_sampler = 1'b0;
  logic              rst_sampler_sync;
  logic              clksampleren_sync;
  logic              start_sync;
  logic [NUM_CH-1:0] sense_in_sync;
  logic [NUM_CH-1:0] ch_mask;
  logic [WIDTH-1:0]  numsamples;
  logic [NUM_CH-1:0] sense_oe;
  logic [NUM_CH-1:0] sense_out;
  logic              drive_oe;
  logic              drive_out;
  logic              data_valid;
  logic              data_ready;
  logic [CH_W-1:0]   data_ch;
  logic [WIDTH-1:0]  data;
  logic              finish;
`ifdef SAMPLER_THRESHOLD_EN
  logic [WIDTH-1:0]  thresh;
  logic [NUM_CH-1:0] touched;
`endif

  int passed = 0;
  int total  = 0;

  logic [NUM_CH-1:0] seq [0:SEQ_N-1];

  always #5 clk_sampler = ~clk_sampler;

  multi_ch_sampler #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .CH_W   (CH_W)
  ) dut (
    .clk_sampler       (clk_sampler),
    .rst_sampler_sync  (rst_sampler_sync),
    .clksampleren_sync (clksampleren_sync),
    .start_sync        (start_sync),
    .sense_in_sync     (sense_in_sync),
    .ch_mask           (ch_mask),
    .numsamples        (numsamples),
    .sense_oe          (sense_oe),
    .sense_out         (sense_out),
    .drive_oe          (drive_oe),
    .drive_out         (drive_out),
    .data_valid        (data_valid),
    .data_ready        (data_ready),
    .data_ch           (data_ch),
    .data              (data),
    .finish            (finish)
`ifdef SAMPLER_THRESHOLD_EN
    ,
    .thresh            (thresh),
    .touched           (touched)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full scan: start, run until finish, release start.
  task automatic run_scan(input logic [NUM_CH-1:0] mask, input int unsigned n_in,
                          input int unsigned pat, input bit gate_en, input bit stall,
                          input logic [WIDTH-1:0] th, output int unsigned first_valid_edge);
    int unsigned n, len, m, idx, k, edges, stall_cnt, budget, j, off, hits, base;
    bit active, adv, e_drv, e_val, e_fin;
    logic [NUM_CH-1:0] e_soe, e_sout, oh, e_touch;
    int unsigned chans[$];
    int unsigned exp_res[$];
    n   = (n_in == 0) ? 1 : n_in;
    len = 2 * n + 5;
    for (int unsigned c = 0; c < NUM_CH; c++) if (mask[c]) chans.push_back(c);
    m = chans.size();
    for (int unsigned t = 0; t < SEQ_N; t++) begin
      off = t % len;
      case (pat)
        0:       seq[t] = NUM_CH'($urandom);
        1:       seq[t] = '0;
        2:       seq[t] = '1;
        default: seq[t] = (off >= n + 4 && off <= 2 * n + 3) ? '1 : '0;
      endcase
    end
    e_touch = '0;
    for (int unsigned q = 0; q < m; q++) begin
      base = q * len;
      hits = 0;
      for (int unsigned s = 0; s < n; s++) begin
        hits += (seq[base + 2 + s][chans[q]] == 1'b0) ? 1 : 0;
        hits += (seq[base + n + 4 + s][chans[q]] == 1'b1) ? 1 : 0;
      end
      exp_res.push_back((hits > SAT) ? SAT : hits);
      if (((hits > SAT) ? SAT : hits) >= int'(th)) e_touch[chans[q]] = 1'b1;
    end

    @(negedge clk_sampler);
    ch_mask = mask; numsamples = WIDTH'(n_in); start_sync = 1'b1;
    clksampleren_sync = 1'b1; data_ready = 1'b1; sense_in_sync = seq[0];
`ifdef SAMPLER_THRESHOLD_EN
    thresh = th;
`endif
    @(posedge clk_sampler);
    edges = 1; idx = 0; k = 0; stall_cnt = 0; first_valid_edge = 0;
    budget = 3 * (m * len + 2) + 6 * m + 20;
    for (int unsigned cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk_sampler);
      sense_in_sync     = seq[idx % SEQ_N];
      ch_mask           = NUM_CH'($urandom);
      numsamples        = WIDTH'($urandom);
      clksampleren_sync = gate_en ? (cyc % 3 == 0) : 1'b1;
      data_ready        = 1'b1;
      if (stall && data_valid === 1'b1 && stall_cnt < 5) begin
        data_ready = 1'b0;
        stall_cnt++;
      end
      j      = idx / len;
      off    = idx % len;
      active = (j < m);
      oh     = active ? NUM_CH'(1 << chans[j]) : '0;
      e_drv  = active && off >= 2 && off <= n + 3;
      e_soe  = (active && off == n + 3) ? oh : '0;
      e_sout = (active && off >= n + 3 && off <= 2 * n + 4) ? oh : '0;
      e_val  = active && off == 2 * n + 4;
      e_fin  = idx > m * len;
      check("pins", 64'({drive_oe, drive_out, sense_oe, sense_out, data_valid, finish}),
            64'({1'b1, e_drv, e_soe, e_sout, e_val, e_fin}));
      if (e_val) begin
        check("data", 64'(data), 64'(exp_res[j]));
        check("data_ch", 64'(data_ch), 64'(chans[j]));
        if (first_valid_edge == 0) first_valid_edge = edges;
      end
      if (finish === 1'b1) break;
      adv = (data_valid === 1'b1) ? data_ready : clksampleren_sync;
      @(posedge clk_sampler);
      edges++;
      if (adv) begin
        if (data_valid === 1'b1 && data_ready) begin
          k++;
          stall_cnt = 0;
        end
        idx++;
      end
    end
    check("scan_finish", 64'(finish), 64'(1));
    check("transfers", 64'(k), 64'(m));
`ifdef SAMPLER_THRESHOLD_EN
    check("touched", 64'(touched), 64'(e_touch));
`endif
    start_sync = 1'b0; clksampleren_sync = 1'b1;
    @(posedge clk_sampler);
    @(negedge clk_sampler);
    check("fin_release", 64'(finish), 64'(0));
  endtask

  initial begin
    int unsigned fv;
    bit bad;
    rst_sampler_sync = 1'b1; clksampleren_sync = 1'b1; start_sync = 1'b0;
    sense_in_sync = '0; ch_mask = '0; numsamples = '0; data_ready = 1'b1;
`ifdef SAMPLER_THRESHOLD_EN
    thresh = '0;
`endif
    repeat (2) @(posedge clk_sampler);
    @(negedge clk_sampler);
    check("rst_pins", 64'({drive_oe, drive_out, sense_oe, sense_out, data_valid, finish}), 64'(12'h800));
    check("rst_data", 64'({data_ch, data}), 64'(0));
    rst_sampler_sync = 1'b0;

    // Two channels, sense low throughout: charge phase hits every sample.
    run_scan(4'b0101, 3, 1, 1'b0, 1'b0, 8'd3, fv);
    // numsamples 0 behaves as 1; first result after 7 enabled edges.
    run_scan(4'b0001, 0, 2, 1'b0, 1'b0, 8'd1, fv);
    check("latency_n0", 64'(fv), 64'(7));
    // 400 raw hits saturate at 255.
    run_scan(4'b0001, 200, 3, 1'b0, 1'b0, 8'd200, fv);
    // Consumer stalls 5 cycles per result.
    run_scan(4'b1111, 5, 0, 1'b0, 1'b1, 8'd5, fv);
    // Clock enable 1-of-3 versus always enabled.
    run_scan(4'b0110, 4, 0, 1'b1, 1'b0, 8'd4, fv);
    run_scan(4'b0110, 4, 0, 1'b0, 1'b0, 8'd4, fv);
    // Empty mask goes straight to FIN.
    run_scan(4'b0000, 3, 0, 1'b0, 1'b0, 8'd0, fv);
    for (int r = 0; r < 5; r++) begin
      int unsigned rn;
      rn = $urandom_range(1, 12);
      run_scan(NUM_CH'($urandom), rn, 0, 1'($urandom), 1'($urandom),
               WIDTH'($urandom_range(0, 2 * rn)), fv);
    end

    // Reset during DISCHARGE of ch1 (mask 0011, n=3: ch1 discharge idx 18..20).
    @(negedge clk_sampler);
    ch_mask = 4'b0011; numsamples = 8'd3; start_sync = 1'b1;
    clksampleren_sync = 1'b1; data_ready = 1'b1;
    @(posedge clk_sampler);
    repeat (19) begin
      @(negedge clk_sampler);
      sense_in_sync = NUM_CH'($urandom);
      @(posedge clk_sampler);
    end
    @(negedge clk_sampler);
    check("pre_rst_dis", 64'({drive_out, sense_oe, sense_out}), 64'({1'b0, 4'b0000, 4'b0010}));
    rst_sampler_sync = 1'b1; start_sync = 1'b0;
    @(posedge clk_sampler);
    @(negedge clk_sampler);
    check("midrst_pins", 64'({drive_oe, drive_out, sense_oe, sense_out, data_valid, finish}), 64'(12'h800));
    check("midrst_data", 64'({data_ch, data}), 64'(0));
`ifdef SAMPLER_THRESHOLD_EN
    check("midrst_touched", 64'(touched), 64'(0));
`endif
    rst_sampler_sync = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk_sampler);
      if (data_valid !== 1'b0 || finish !== 1'b0 || drive_out !== 1'b0) bad = 1'b1;
    end
    check("idle_after_rst", 64'(bad), 64'(0));
    run_scan(4'b0001, 0, 2, 1'b0, 1'b0, 8'd1, fv);
    check("latency_after_rst", 64'(fv), 64'(7));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
